fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that lets NUM_REQ independent producers share one synchronous FIFO write port.
- Each producer has a valid/ready/data handshake.
- The arbiter grants one owner at a time for a bounded burst and drives the FIFO's wr_en/data_in.
- It back-pressures every producer from the FIFO's full flag.
- It sits directly in front of the team's fifo block. A FIFO write happens iff fifo_wr_en is high and fifo_full is low.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, per-requester data width; equals the FIFO DATA_WIDTH
MAX_BURST, 4, max beats accepted per grant before forced release (1..256)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
req_valid  input  NUM_REQ  per-requester data valid
req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester accept; a beat transfers when valid && ready
fifo_full  input  1  FIFO full flag
fifo_wr_en  output  1  FIFO write enable
fifo_data_in  output  DATA_WIDTH  FIFO write data
grant  output  NUM_REQ  one-hot current owner; all-zero in IDLE
busy  output  1  high in BURST state

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, last_owner=NUM_REQ-1, beat_cnt=0.
  - grant=0, busy=0, req_ready=0, fifo_wr_en=0, fifo_data_in=0.
- States: IDLE, BURST. The state is the only registered control besides owner, last_owner and beat_cnt.
- IDLE:
  - If any req_valid is high, pick the first set bit scanning from (last_owner+1) mod NUM_REQ upward with wrap.
  - Register it as owner, clear beat_cnt, go to BURST.
  - Otherwise stay in IDLE.
  - No beat is accepted in IDLE, so there is a 1-cycle arbitration bubble per grant.
- BURST, combinational outputs:
  - req_ready[owner] = !fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[owner] && !fifo_full.
  - fifo_data_in = req_data slice of owner. Outside BURST it is 0.
  - Write latency: zero. A data beat enters the FIFO on the same edge it is accepted.
- BURST, leaving the state:
  - If a beat is accepted and beat_cnt==MAX_BURST-1: go to IDLE, last_owner=owner.
  - Else if req_valid[owner]==0: go to IDLE, last_owner=owner. This applies whether or not the FIFO is full.
  - Else if a beat is accepted: beat_cnt+1.
  - Else (stalled by fifo_full): hold state, owner and beat_cnt.
- beat_cnt width is $clog2(MAX_BURST)+1 and never exceeds MAX_BURST-1.
- MAX_BURST=1: every grant ends after exactly one beat.
- Fairness: a requester asserting valid continuously is granted within NUM_REQ grants.
- Requesters must hold valid and data stable until ready. The arbiter does not buffer any data.
- Reset asserted mid-burst:
  - The beat presented in that cycle is not written; fifo_wr_en is forced low while reset==0.
  - All state returns to reset values.

Optional Feature:
Macro FIFO_WR_ARBITER_STATS_EN.
- Defined: adds input stat_clr (1) and output stat_beats (NUM_REQ*16).
  - Per-requester 16-bit counter of accepted beats, saturating at 16'hFFFF.
  - Counters reset to 0 and are cleared by stat_clr. If stat_clr coincides with an accepted beat, the clear wins.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state encoding constants (ST_IDLE=1'b0, ST_BURST=1'b1),
  - STAT_WIDTH=16,
  - a function computing beat_cnt width from MAX_BURST.
- One sub-module, fifo_rr_pick:
  - combinational NUM_REQ-wide round-robin picker;
  - inputs: req vector and last_owner index;
  - outputs: any_req and the picked index.
- FSM, counters and muxing stay in fifo_wr_arbiter.

Test Plan:
All scenarios use NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4, fifo_full=0 unless stated.
1. Reset sequence: hold reset=0 for 3 cycles with req_valid=4'b1111 -> grant=0, fifo_wr_en=0, all req_ready=0; first grant after release goes to requester 0.
2. Burst limit: requester 1 alone streams 6 beats 0x10..0x15 -> FIFO receives 0x10..0x13, then 1 IDLE cycle, then 0x14,0x15 in a second grant to requester 1.
3. Round-robin: all four valid continuously -> grant order 0,1,2,3,0 with 4 beats each; data written in exactly that order.
4. Back-pressure: fifo_full=1 for 3 cycles mid-burst of requester 2 after 2 beats -> no writes, grant held, beat_cnt stays 2; on release the remaining 2 beats are written, then requester 2 is released.
5. Early release: requester 3 drops valid after 1 beat while requester 0 is waiting -> one IDLE cycle, then grant=4'b0001.
6. Reset mid-burst with a beat pending -> no write on that edge; the next grant again starts at requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
//==============================================================================
// Package : fifo_arb_pkg
// Shared state encoding, statistics width and beat counter sizing for fifo_wr_arbiter.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  localparam int STAT_WIDTH = 16;

  // One spare bit keeps MAX_BURST-1 representable for every legal MAX_BURST.
  function automatic int beat_cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
//==============================================================================
// Interface : fifo_wr_arbiter_if
// Producer handshakes plus FIFO write port; master = arbiter side, slave = environment.
// Optional statistics signals exist only with FIFO_WR_ARBITER_STATS_EN.
// Rev       : 1.0
//==============================================================================
`default_nettype none

interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic                                           stat_clr;
  logic [NUM_REQ*fifo_arb_pkg::STAT_WIDTH-1:0]    stat_beats;
`endif

  modport master (
    input  req_valid, req_data, fifo_full,
`ifdef FIFO_WR_ARBITER_STATS_EN
    input  stat_clr,
    output stat_beats,
`endif
    output req_ready, fifo_wr_en, fifo_data_in, grant, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full,
`ifdef FIFO_WR_ARBITER_STATS_EN
    output stat_clr,
    input  stat_beats,
`endif
    input  req_ready, fifo_wr_en, fifo_data_in, grant, busy
  );

endinterface

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
//==============================================================================
// Module : fifo_rr_pick
// Combinational round-robin picker: first set request after last, wrapping around.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module fifo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               any_req,
  output logic [IDX_W-1:0]   pick
);

  logic [IDX_W-1:0] w_cand;

  // Walk from farthest to nearest so the nearest candidate after last wins.
  always_comb begin
    any_req = |req;
    pick    = '0;
    w_cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (req[w_cand]) begin
        pick = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
//==============================================================================
// Module : fifo_wr_arbiter
// Round-robin bounded-burst arbiter sharing one FIFO write port among producers.
// Optional per-requester beat counters: FIFO_WR_ARBITER_STATS_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                clk,
  input  logic                reset,
  fifo_wr_arbiter_if.master   bus
);

  import fifo_arb_pkg::*;

  localparam int                IDX_W     = $clog2(NUM_REQ);
  localparam int                CNT_W     = beat_cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_last_owner;
  logic [CNT_W-1:0] r_beat_cnt;

  logic             w_any_req;
  logic [IDX_W-1:0] w_pick;
  logic             w_active;
  logic             w_owner_valid;
  logic             w_accept;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (bus.req_valid),
    .last    (r_last_owner),
    .any_req (w_any_req),
    .pick    (w_pick)
  );

  // Outputs are gated by reset so a beat presented during reset is never written.
  assign w_active      = (r_state == ST_BURST) && reset;
  assign w_owner_valid = bus.req_valid[r_owner];
  assign w_accept      = w_active && w_owner_valid && !bus.fifo_full;

  assign bus.fifo_wr_en = w_accept;
  assign bus.busy       = w_active;

  always_comb begin
    bus.req_ready    = '0;
    bus.grant        = '0;
    bus.fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_active && (r_owner == IDX_W'(i))) begin
        bus.req_ready[i] = !bus.fifo_full;
        bus.grant[i]     = 1'b1;
        bus.fifo_data_in = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner    <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_accept && (r_beat_cnt == LAST_BEAT)) begin
            r_state      <= ST_IDLE;
            r_last_owner <= r_owner;
          end else if (!w_owner_valid) begin
            r_state      <= ST_IDLE;
            r_last_owner <= r_owner;
          end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
      logic [STAT_WIDTH-1:0] r_beats;

      // Clear takes priority over a coincident beat; counters stick at all-ones.
      always_ff @(posedge clk) begin
        if (!reset || bus.stat_clr) begin
          r_beats <= '0;
        end else if (w_accept && (r_owner == IDX_W'(i)) && (r_beats != '1)) begin
          r_beats <= r_beats + 1'b1;
        end
      end

      assign bus.stat_beats[i*STAT_WIDTH +: STAT_WIDTH] = r_beats;
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
//==============================================================================
// Module : tb_fifo_wr_arbiter
// Scoreboard bench: directed scenarios queue expected FIFO writes, a monitor checks them.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NR-1:0] grant;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  exp_t          sb [$];
  logic [DW-1:0] src [NR][$];
  logic [NR-1:0] acc_mask = '0;
  int            n_vec = 0;
  int            n_bad = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int r, input logic [DW-1:0] first, input int n);
    for (int k = 0; k < n; k++) src[r].push_back(DW'(first + k));
  endtask

  task automatic expect_wr(input int o, input logic [DW-1:0] d);
    exp_t e;
    e.data     = d;
    e.grant    = '0;
    e.grant[o] = 1'b1;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      done = (sb.size() == 0) && (bus.grant == '0) &&
             (src[0].size() == 0) && (src[1].size() == 0) &&
             (src[2].size() == 0) && (src[3].size() == 0);
    end
    check({name, "_pending_writes"}, sb.size(), 0);
    check({name, "_idle_grant"}, 32'(bus.grant), 0);
  endtask

  // Producers: retire accepted beats, then present the next queued beat.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (acc_mask[i] && (src[i].size() != 0)) void'(src[i].pop_front());
        bus.req_valid[i]          = (src[i].size() != 0);
        bus.req_data[i*DW +: DW]  = (src[i].size() != 0) ? src[i][0] : '0;
      end
    end
  end

  // Monitor: every FIFO write must match the next expected beat and owner.
  always @(negedge clk) begin
    exp_t e;
    acc_mask = bus.req_valid & bus.req_ready;
    if (bus.fifo_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("extra_write", 32'(bus.fifo_data_in), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("wr_data", 32'(bus.fifo_data_in), 32'(e.data));
        check("wr_grant", 32'(bus.grant), 32'(e.grant));
      end
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  initial bus.stat_clr = 1'b0;
`endif

  initial begin
    logic [7:0]    pat2;
    logic [10:0]   pat4;
    logic [NR-1:0] exp5 [4];
    exp5 = '{4'b1000, 4'b1000, 4'b0000, 4'b0001};
    bus.fifo_full = 1'b0;

    // 1: reset with all requesters valid, first grant goes to requester 0
    for (int i = 0; i < NR; i++) begin
      load(i, DW'(8'hA0 + i), 1);
      expect_wr(i, DW'(8'hA0 + i));
    end
    repeat (3) begin
      @(negedge clk);
      check("s1_rst_grant", 32'(bus.grant), 0);
      check("s1_rst_wr_en", 32'(bus.fifo_wr_en), 0);
      check("s1_rst_ready", 32'(bus.req_ready), 0);
      check("s1_rst_busy", 32'(bus.busy), 0);
    end
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("s1_first_grant", 32'(bus.grant), 32'b0001);
    drain("s1");

    // 2: requester 1 alone, six beats split 4 + 2 with one bubble
    tick();
    load(1, 8'h10, 6);
    for (int k = 0; k < 6; k++) expect_wr(1, DW'(8'h10 + k));
    pat2 = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      @(negedge clk);
      pat2 = {pat2[6:0], bus.fifo_wr_en};
    end
    check("s2_wr_pattern", 32'(pat2), 32'b11110110);
    drain("s2");

    // 3: all four streaming, order 0,1,2,3,0 with 4 beats each
    do_reset();
    tick();
    load(0, 8'h00, 8);
    load(1, 8'h40, 4);
    load(2, 8'h80, 4);
    load(3, 8'hC0, 4);
    for (int k = 0; k < 4; k++) expect_wr(0, DW'(8'h00 + k));
    for (int k = 0; k < 4; k++) expect_wr(1, DW'(8'h40 + k));
    for (int k = 0; k < 4; k++) expect_wr(2, DW'(8'h80 + k));
    for (int k = 0; k < 4; k++) expect_wr(3, DW'(8'hC0 + k));
    for (int k = 0; k < 4; k++) expect_wr(0, DW'(8'h04 + k));
    drain("s3");

    // 4: FIFO full for 3 cycles after 2 beats of requester 2
    tick();
    load(2, 8'h50, 6);
    for (int k = 0; k < 6; k++) expect_wr(2, DW'(8'h50 + k));
    pat4 = '0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      bus.fifo_full = (c >= 3) && (c <= 5);
      @(negedge clk);
      pat4 = {pat4[9:0], bus.fifo_wr_en};
      if (c == 4) begin
        check("s4_stall_grant", 32'(bus.grant), 32'b0100);
        check("s4_stall_ready", 32'(bus.req_ready), 0);
        check("s4_stall_busy", 32'(bus.busy), 1);
      end
    end
    check("s4_wr_pattern", 32'(pat4), 32'b11000110110);
    drain("s4");

    // 5: requester 3 drops valid after one beat while requester 0 waits
    tick();
    load(3, 8'h73, 1);
    expect_wr(3, 8'h73);
    expect_wr(0, 8'h0A);
    expect_wr(0, 8'h0B);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) load(0, 8'h0A, 2);
      @(negedge clk);
      check($sformatf("s5_grant_c%0d", c), 32'(bus.grant), 32'(exp5[c-1]));
    end
    drain("s5");

    // 6: reset mid-burst of requester 1; next grant restarts at requester 0
    tick();
    load(1, 8'h61, 3);
    expect_wr(1, 8'h61);
    expect_wr(0, 8'h6A);
    expect_wr(1, 8'h62);
    expect_wr(1, 8'h63);
    expect_wr(2, 8'h64);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) begin
        reset = 1'b0;
        load(0, 8'h6A, 1);
        load(2, 8'h64, 1);
      end
      if (c == 4) reset = 1'b1;
      @(negedge clk);
      if (c == 1) check("s6_first_beat", 32'(bus.fifo_wr_en), 1);
      if (c == 2) begin
        check("s6_rst_wr_en", 32'(bus.fifo_wr_en), 0);
        check("s6_rst_ready", 32'(bus.req_ready), 0);
      end
    end
    tick();
    @(negedge clk);
    check("s6_regrant", 32'(bus.grant), 32'b0001);
    drain("s6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
